// File: rtl/scan_seq_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the scan sequencer.
package scan_seq_pkg;

    localparam int DEF_CHAIN_LEN   = 16;
    localparam int DEF_CAP_WAIT    = 4;
    localparam int DEF_CAP_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_RECOVER,
        ST_UNLOAD,
        ST_DONE
    } scan_seq_state_t;

    // One counter serves every timed phase, so it must hold the longest reload value.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Handshake bundle between the scan sequencer, the chain drivers and the capture generator.
interface scan_seq_ctrl_if #(
    parameter int PAT_W = 8
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] num_patterns;
    logic             capture_ack;
    logic             shift_en;
    logic             scan_clk_en;
    logic             capture_req;
    logic             last_unload;
    logic [PAT_W-1:0] pattern_idx;
    logic             busy;
    logic             done;
    logic             cap_timeout;

    modport master (
        output start, abort, num_patterns, capture_ack,
        input  shift_en, scan_clk_en, capture_req, last_unload,
        input  pattern_idx, busy, done, cap_timeout
    );

    modport slave (
        input  start, abort, num_patterns, capture_ack,
        output shift_en, scan_clk_en, capture_req, last_unload,
        output pattern_idx, busy, done, cap_timeout
    );
endinterface

// File: rtl/scan_seq_counter.sv
// Loadable down-counter that parks at zero; tc flags the last cycle of a timed phase.
module scan_seq_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/scan_seq_ctrl.sv
// At-speed scan sequencer: shift / settle / capture handshake / recover per pattern, then final unload.
// Optional capture timeout enabled by defining SCAN_CAP_TIMEOUT_EN.
module scan_seq_ctrl
    import scan_seq_pkg::*;
#(
    parameter int CHAIN_LEN   = DEF_CHAIN_LEN,
    parameter int PAT_W       = 8,
    parameter int CAP_WAIT    = DEF_CAP_WAIT,
    parameter int CAP_TIMEOUT = DEF_CAP_TIMEOUT
) (
    input logic            clk,
    input logic            rst,
    scan_seq_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_width(CHAIN_LEN, CAP_WAIT, CAP_TIMEOUT);
    localparam logic [CNT_W-1:0] SHIFT_LOAD  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(CAP_WAIT - 1);
`ifdef SCAN_CAP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(CAP_TIMEOUT - 1);
`endif

    scan_seq_state_t  state_reg;
    logic             shift_en_reg;
    logic             scan_clk_en_reg;
    logic             capture_req_reg;
    logic             last_unload_reg;
    logic [PAT_W-1:0] pattern_idx_reg;
    logic [PAT_W-1:0] num_pat_reg;
    logic             busy_reg;
    logic             done_reg;
`ifdef SCAN_CAP_TIMEOUT_EN
    logic             cap_timeout_reg;
`endif

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tc;
    logic [PAT_W:0]   idx_inc;
    logic             more_patterns;

    // One extra bit so a full 2^PAT_W-1 pattern count never wraps the comparison.
    assign idx_inc       = {1'b0, pattern_idx_reg} + {{PAT_W{1'b0}}, 1'b1};
    assign more_patterns = (idx_inc < {1'b0, num_pat_reg});

    // Counter reloads on the same edge that enters the timed phase.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = SHIFT_LOAD;
        case (state_reg)
            ST_IDLE:    cnt_load = bus.start;
            ST_SHIFT: begin
                cnt_load = cnt_tc;
                cnt_val  = SETTLE_LOAD;
            end
`ifdef SCAN_CAP_TIMEOUT_EN
            ST_SETTLE: begin
                cnt_load = cnt_tc;
                cnt_val  = TIMEOUT_LOAD;
            end
`endif
            ST_RECOVER: cnt_load = 1'b1;
            default:    cnt_load = 1'b0;
        endcase
    end

    scan_seq_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            shift_en_reg    <= 1'b1;
            scan_clk_en_reg <= 1'b0;
            capture_req_reg <= 1'b0;
            last_unload_reg <= 1'b0;
            pattern_idx_reg <= '0;
            num_pat_reg     <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
`ifdef SCAN_CAP_TIMEOUT_EN
            cap_timeout_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (bus.abort) begin
                // pattern_idx and the timeout flag are kept for post-mortem inspection
                state_reg       <= ST_IDLE;
                shift_en_reg    <= 1'b1;
                scan_clk_en_reg <= 1'b0;
                capture_req_reg <= 1'b0;
                last_unload_reg <= 1'b0;
                busy_reg        <= 1'b0;
            end else begin
                unique case (state_reg)
                    ST_IDLE: begin
                        if (bus.start) begin
                            num_pat_reg     <= bus.num_patterns;
                            pattern_idx_reg <= '0;
                            busy_reg        <= 1'b1;
`ifdef SCAN_CAP_TIMEOUT_EN
                            cap_timeout_reg <= 1'b0;
`endif
                            if (bus.num_patterns == '0) begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg       <= ST_SHIFT;
                                shift_en_reg    <= 1'b1;
                                scan_clk_en_reg <= 1'b1;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (cnt_tc) begin
                            state_reg       <= ST_SETTLE;
                            shift_en_reg    <= 1'b0;
                            scan_clk_en_reg <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_tc) begin
                            state_reg       <= ST_CAPTURE;
                            capture_req_reg <= 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        if (bus.capture_ack) begin
                            state_reg       <= ST_RECOVER;
                            capture_req_reg <= 1'b0;
                        end
`ifdef SCAN_CAP_TIMEOUT_EN
                        else if (cnt_tc) begin
                            state_reg       <= ST_DONE;
                            capture_req_reg <= 1'b0;
                            cap_timeout_reg <= 1'b1;
                            shift_en_reg    <= 1'b1;
                            done_reg        <= 1'b1;
                        end
`endif
                    end
                    ST_RECOVER: begin
                        state_reg       <= more_patterns ? ST_SHIFT : ST_UNLOAD;
                        shift_en_reg    <= 1'b1;
                        scan_clk_en_reg <= 1'b1;
                        if (more_patterns) begin
                            pattern_idx_reg <= idx_inc[PAT_W-1:0];
                        end else begin
                            last_unload_reg <= 1'b1;
                        end
                    end
                    ST_UNLOAD: begin
                        if (cnt_tc) begin
                            state_reg       <= ST_DONE;
                            scan_clk_en_reg <= 1'b0;
                            last_unload_reg <= 1'b0;
                            done_reg        <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.shift_en    = shift_en_reg;
    assign bus.scan_clk_en = scan_clk_en_reg;
    assign bus.capture_req = capture_req_reg;
    assign bus.last_unload = last_unload_reg;
    assign bus.pattern_idx = pattern_idx_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
`ifdef SCAN_CAP_TIMEOUT_EN
    assign bus.cap_timeout = cap_timeout_reg;
`else
    assign bus.cap_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Scoreboard bench for scan_seq_ctrl: a pattern-level model queues expected windows/captures/done,
// a monitor reconstructs the same events from the pins and compares.
module tb_scan_seq_ctrl;

    localparam int CHAIN_LEN   = 16;
    localparam int PAT_W       = 8;
    localparam int CAP_WAIT    = 4;
    localparam int CAP_TIMEOUT = 64;

    localparam int K_WIN  = 0;
    localparam int K_CAP  = 1;
    localparam int K_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    scan_seq_ctrl_if #(.PAT_W(PAT_W)) bus();

    scan_seq_ctrl #(
        .CHAIN_LEN   (CHAIN_LEN),
        .PAT_W       (PAT_W),
        .CAP_WAIT    (CAP_WAIT),
        .CAP_TIMEOUT (CAP_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // WIN: a=length b=last_unload c=shift_en held high; CAP: a=idx b=low cycles before c=busy;
    // DONE: a=idx b=cap_timeout c=busy
    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  hold_ack    = 1'b0;
    bit  spurious_en = 1'b1;
    int  last_req_len = 0;

    function automatic string kname(input int k);
        case (k)
            K_WIN:   return "WIN";
            K_CAP:   return "CAP";
            default: return "DONE";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("txn %s = %0d ok", name, act);
        end
    endtask

    task automatic observe(input ev_t o);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s actual=(%0d,%0d,%0d) required=no event",
                     kname(o.kind), o.a, o.b, o.c);
            return;
        end
        e = exp_q.pop_front();
        if (o.kind != e.kind || o.a != e.a || o.b != e.b || o.c != e.c) begin
            failures++;
            $display("FAIL ev_%s actual=%s(%0d,%0d,%0d) required=%s(%0d,%0d,%0d)",
                     kname(e.kind), kname(o.kind), o.a, o.b, o.c, kname(e.kind), e.a, e.b, e.c);
        end else begin
            $display("txn %s a=%0d b=%0d c=%0d ok", kname(o.kind), o.a, o.b, o.c);
        end
    endtask

    // Pattern-level model: each pattern is one full shift window and one capture.
    task automatic model_run(input int n);
        if (n == 0) begin
            exp_q.push_back('{K_DONE, 0, 0, 1});
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{K_WIN, CHAIN_LEN, 0, 1});
            exp_q.push_back('{K_CAP, i, CAP_WAIT, 1});
        end
        exp_q.push_back('{K_WIN, CHAIN_LEN, 1, 1});
        exp_q.push_back('{K_DONE, n - 1, 0, 1});
    endtask

    task automatic pulse_start(input int n);
        bus.num_patterns = PAT_W'(n);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.num_patterns = PAT_W'($urandom);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int cnt = 0;
        while (bus.busy === 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", name, budget);
        end
    endtask

    task automatic run_seq(input int n, input bit stray);
        model_run(n);
        pulse_start(n);
        if (stray && bus.busy === 1'b1) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            if (bus.busy === 1'b1) begin
                bus.num_patterns = PAT_W'($urandom);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        wait_idle("run", (n + 1) * (CHAIN_LEN + CAP_WAIT + 12) + 20);
        repeat (2) @(negedge clk);
    endtask

    // Capture generator stand-in: acks after a random delay, and throws stray acks outside CAPTURE.
    initial begin : responder
        int wait_cnt = 0;
        int dly = 2;
        bus.capture_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.capture_ack) begin
                bus.capture_ack = 1'b0;
            end else if (bus.capture_req === 1'b1) begin
                if (!hold_ack) begin
                    if (wait_cnt >= dly) begin
                        bus.capture_ack = 1'b1;
                        wait_cnt = 0;
                        dly = $urandom_range(0, 5);
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
                if (spurious_en && $urandom_range(0, 5) == 0) bus.capture_ack = 1'b1;
            end
        end
    end

    initial begin : monitor
        int win_len = 0;
        bit win_unload = 1'b0;
        bit win_shift_ok = 1'b1;
        int low_cnt = 0;
        bit prev_req = 1'b0;
        int req_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                win_len = 0; win_unload = 1'b0; win_shift_ok = 1'b1;
                low_cnt = 0; prev_req = 1'b0; req_len = 0;
            end else begin
                if (bus.scan_clk_en === 1'b1) begin
                    win_len++;
                    win_unload |= (bus.last_unload === 1'b1);
                    if (bus.shift_en !== 1'b1) win_shift_ok = 1'b0;
                end else if (win_len > 0) begin
                    observe('{K_WIN, win_len, int'(win_unload), int'(win_shift_ok)});
                    win_len = 0; win_unload = 1'b0; win_shift_ok = 1'b1;
                end
                if (bus.capture_req === 1'b1 && !prev_req)
                    observe('{K_CAP, int'(bus.pattern_idx), low_cnt, int'(bus.busy)});
                if (bus.capture_req === 1'b1) begin
                    req_len++;
                end else if (prev_req) begin
                    last_req_len = req_len;
                    req_len = 0;
                end
                prev_req = (bus.capture_req === 1'b1);
                low_cnt = (bus.shift_en === 1'b0) ? low_cnt + 1 : 0;
                if (bus.done === 1'b1)
                    observe('{K_DONE, int'(bus.pattern_idx), int'(bus.cap_timeout), int'(bus.busy)});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cnt;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_patterns = '0;
        repeat (2) @(negedge clk);

        check("rst_shift_en", bus.shift_en, 1);
        check("rst_scan_clk_en", bus.scan_clk_en, 0);
        check("rst_capture_req", bus.capture_req, 0);
        check("rst_last_unload", bus.last_unload, 0);
        check("rst_pattern_idx", bus.pattern_idx, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cap_timeout", bus.cap_timeout, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // three patterns, first ack two cycles after request
        run_seq(3, 1'b0);

        // zero patterns: straight to DONE
        model_run(0);
        pulse_start(0);
        check("zero_done", bus.done, 1);
        check("zero_busy", bus.busy, 1);
        check("zero_shift_en", bus.shift_en, 1);
        @(negedge clk);
        check("zero_idle_busy", bus.busy, 0);
        check("zero_idle_done", bus.done, 0);
        repeat (2) @(negedge clk);

        // abort in cycle 5 of pattern 1's shift window
        exp_q.push_back('{K_WIN, CHAIN_LEN, 0, 1});
        exp_q.push_back('{K_CAP, 0, CAP_WAIT, 1});
        exp_q.push_back('{K_WIN, 5, 0, 1});
        pulse_start(3);
        cnt = 0;
        while (!(bus.scan_clk_en === 1'b1 && bus.pattern_idx === PAT_W'(1)) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) begin
            checks++;
            failures++;
            $display("FAIL abort_reach actual=no pattern 1 shift required=within 200 cycles");
        end
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_shift_en", bus.shift_en, 1);
        check("abort_scan_clk_en", bus.scan_clk_en, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_pattern_idx", bus.pattern_idx, 1);
        repeat (3) @(negedge clk);
        run_seq(2, 1'b0);

`ifdef SCAN_CAP_TIMEOUT_EN
        hold_ack = 1'b1;
        spurious_en = 1'b0;
        exp_q.push_back('{K_WIN, CHAIN_LEN, 0, 1});
        exp_q.push_back('{K_CAP, 0, CAP_WAIT, 1});
        exp_q.push_back('{K_DONE, 0, 1, 1});
        pulse_start(2);
        wait_idle("timeout", CHAIN_LEN + CAP_WAIT + CAP_TIMEOUT + 20);
        check("timeout_req_len", last_req_len, CAP_TIMEOUT);
        check("timeout_sticky", bus.cap_timeout, 1);
        hold_ack = 1'b0;
        spurious_en = 1'b1;
        model_run(1);
        pulse_start(1);
        check("timeout_cleared", bus.cap_timeout, 0);
        wait_idle("timeout_rerun", 100);
        repeat (2) @(negedge clk);
`endif

        // randomized runs with stray acks and stray start pulses
        for (int r = 0; r < 8; r++) run_seq($urandom_range(0, 6), 1'b1);

        // async reset while waiting for capture_ack
        hold_ack = 1'b1;
        exp_q.push_back('{K_WIN, CHAIN_LEN, 0, 1});
        exp_q.push_back('{K_CAP, 0, CAP_WAIT, 1});
        pulse_start(4);
        cnt = 0;
        while (bus.capture_req !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_capture_req", bus.capture_req, 0);
        check("arst_shift_en", bus.shift_en, 1);
        check("arst_busy", bus.busy, 0);
        check("arst_pattern_idx", bus.pattern_idx, 0);
        check("arst_scan_clk_en", bus.scan_clk_en, 0);
        @(negedge clk);
        rst = 1'b0;
        hold_ack = 1'b0;
        repeat (2) @(negedge clk);

        // full pattern count: index must reach 2^PAT_W-2 without wrapping
        run_seq((1 << PAT_W) - 1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
